// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and lane constants for the memory access sequencer
package mem_pkg;

    typedef enum logic [1:0] {
        SIZE_WORD = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_BYTE = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        DONE = 2'b11
    } mem_state_t;

    // Lane positions shared with the load-extraction stage
    localparam int HW_LSB   = 16;
    localparam int BYTE_LSB = 24;

    // Halfword and byte stores need a read-modify-write; size 11 behaves as word
    function automatic logic is_partial(input logic [1:0] size);
        return (size == SIZE_HALF) || (size == SIZE_BYTE);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_store_merge.sv
// rtl/mem_access_ctrl_store_merge.sv - places partial store data into the lane the load side reads
module store_merge
    import mem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_merged
);

    // Upper lanes take the new data, lower bits keep the old memory word
    always_comb begin
        o_merged = i_store_data;
        case (i_size)
            SIZE_HALF: o_merged = {i_store_data[15:0], i_rdata[HW_LSB-1:0]};
            SIZE_BYTE: o_merged = {i_store_data[7:0],  i_rdata[BYTE_LSB-1:0]};
            default:   o_merged = i_store_data;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - multicycle load/store sequencer with read-modify-write and request timeout
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int AW             = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          is_store,
    input  logic [1:0]    size,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   store_data,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [31:0]   mdr,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ack
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    mem_state_t     r_state;
    mem_state_t     w_next;
    logic           r_is_store;
    logic [1:0]     r_size;
    logic [31:0]    r_store_data;
    logic [AW-1:0]  r_mem_addr;
    logic [31:0]    r_mem_wdata;
    logic [31:0]    r_mdr;
    logic [CW-1:0]  r_cnt;
    logic           r_err;

    logic           w_in_req;
    logic           w_partial;
    logic           w_timeout;
    logic [31:0]    w_merged;
    logic           w_unused_addr_lsbs;

    // Byte offset within the word is irrelevant: accesses are always word aligned
    assign w_unused_addr_lsbs = ^addr[1:0];

    assign w_in_req  = (r_state == RD) || (r_state == WR);
    assign w_partial = r_is_store && is_partial(r_size);
    // An ack in the final wait cycle takes priority over the abort
    assign w_timeout = w_in_req && !mem_ack && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    assign mdr       = r_mdr;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    store_merge u_store_merge (
        .i_size       (r_size),
        .i_store_data (r_store_data),
        .i_rdata      (mem_rdata),
        .o_merged     (w_merged)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection: word stores skip the read phase
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = (is_store && !is_partial(size)) ? WR : RD;
                end
            end
            RD: begin
                if (mem_ack) begin
                    w_next = w_partial ? WR : DONE;
                end else if (w_timeout) begin
                    w_next = DONE;
                end
            end
            WR: begin
                if (mem_ack || w_timeout) begin
                    w_next = DONE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Handshake and memory strobes decoded from the current state
    always_comb begin
        busy    = (r_state != IDLE);
        done    = (r_state == DONE);
        err     = (r_state == DONE) && r_err;
        mem_req = w_in_req;
        mem_we  = (r_state == WR);
    end

    // Request latching, wait counter, read capture and merge write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_store   <= 1'b0;
            r_size       <= 2'b00;
            r_store_data <= 32'h0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 32'h0;
            r_mdr        <= 32'h0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_is_store   <= is_store;
                        r_size       <= size;
                        r_store_data <= store_data;
                        r_mem_addr   <= {addr[AW-1:2], 2'b00};
                        r_cnt        <= '0;
                        r_err        <= 1'b0;
                        if (is_store && !is_partial(size)) begin
                            r_mem_wdata <= store_data;
                        end
                    end
                end
                RD: begin
                    if (mem_ack) begin
                        r_cnt <= '0;
                        if (w_partial) begin
                            r_mem_wdata <= w_merged;
                        end else begin
                            r_mdr <= mem_rdata;
                        end
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WR: begin
                    if (!mem_ack) begin
                        if (w_timeout) begin
                            r_err <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
